// File: rtl/register_write_arbiter_pkg.sv
// Shared constants for the register write-port arbiter: widths, the parking
// register id and the grant encodings.
package register_write_arbiter_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ID_W   = 4;

  // register_block discards writes to this id, so it doubles as "no write".
  localparam logic [ID_W-1:0] NULL_ID = 4'd15;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with its priority pointer register.
// The pointer always moves to the requester that was not just served.
module rr_arbiter2
  import register_write_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o,
  output logic ptr_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    // Readies are forced low while reset is held, even though it is async.
    gnt_a_o = rst_ni && req_a_i && (!req_b_i || (ptr_q == GRANT_A));
    gnt_b_o = rst_ni && req_b_i && (!req_a_i || (ptr_q == GRANT_B));
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_a_o) begin
      ptr_d = GRANT_B;
    end else if (gnt_b_o) begin
      ptr_d = GRANT_A;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= GRANT_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/register_write_arbiter.sv
// Shares the single register_block write port between an ALU (A) and a load
// (B) requester, with a registered output stage and read-hazard flags.
module register_write_arbiter
  import register_write_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic [ID_W-1:0]   a_id,
  input  logic [DATA_W-1:0] a_value,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ID_W-1:0]   b_id,
  input  logic [DATA_W-1:0] b_value,
  output logic              b_ready,
  output logic [ID_W-1:0]   write_id,
  output logic [DATA_W-1:0] write_value,
  input  logic [ID_W-1:0]   q1_id,
  output logic              q1_hazard,
  input  logic [ID_W-1:0]   q2_id,
  output logic              q2_hazard,
  output logic              last_grant
);

  logic              gnt_a, gnt_b;
  logic              ptr_unused;
  logic [ID_W-1:0]   write_id_q, write_id_d;
  logic [DATA_W-1:0] write_value_q, write_value_d;
  logic              last_grant_q, last_grant_d;

  rr_arbiter2 u_rr_arbiter2 (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .req_a_i (a_valid),
    .req_b_i (b_valid),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b),
    .ptr_o   (ptr_unused)
  );

  // With no write enable downstream, an idle cycle must park on NULL_ID.
  always_comb begin
    write_id_d    = NULL_ID;
    write_value_d = '0;
    last_grant_d  = last_grant_q;
    if (gnt_a) begin
      write_id_d    = a_id;
      write_value_d = a_value;
      last_grant_d  = GRANT_A;
    end else if (gnt_b) begin
      write_id_d    = b_id;
      write_value_d = b_value;
      last_grant_d  = GRANT_B;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_id_q    <= NULL_ID;
      write_value_q <= '0;
      last_grant_q  <= GRANT_A;
    end else begin
      write_id_q    <= write_id_d;
      write_value_q <= write_value_d;
      last_grant_q  <= last_grant_d;
    end
  end

  always_comb begin
    q1_hazard = (q1_id != NULL_ID) &&
                ((q1_id == write_id_q) || (a_valid && (q1_id == a_id)) ||
                 (b_valid && (q1_id == b_id)));
    q2_hazard = (q2_id != NULL_ID) &&
                ((q2_id == write_id_q) || (a_valid && (q2_id == a_id)) ||
                 (b_valid && (q2_id == b_id)));
  end

  assign a_ready     = gnt_a;
  assign b_ready     = gnt_b;
  assign write_id    = write_id_q;
  assign write_value = write_value_q;
  assign last_grant  = last_grant_q;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter with a behavioural register_block
// stand-in that commits the write port at each rising edge.
module tb_register_write_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       a_valid, b_valid;
  logic [3:0] a_id, b_id;
  logic [7:0] a_value, b_value;
  logic       a_ready, b_ready;
  logic [3:0] write_id;
  logic [7:0] write_value;
  logic [3:0] q1_id, q2_id;
  logic       q1_hazard, q2_hazard;
  logic       last_grant;

  int total = 0;
  int bad   = 0;

  logic [7:0] regs [16] = '{default: 8'h00};

  always #5 clock = ~clock;

  // Register file stand-in: writes to id 15 vanish.
  always @(posedge clock) begin
    if (write_id != 4'd15) regs[write_id] <= write_value;
  end

  register_write_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_valid     (a_valid),
    .a_id        (a_id),
    .a_value     (a_value),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_id        (b_id),
    .b_value     (b_value),
    .b_ready     (b_ready),
    .write_id    (write_id),
    .write_value (write_value),
    .q1_id       (q1_id),
    .q1_hazard   (q1_hazard),
    .q2_id       (q2_id),
    .q2_hazard   (q2_hazard),
    .last_grant  (last_grant)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    a_valid = 1'b1; a_id = 4'd2; a_value = 8'h12;
    b_valid = 1'b1; b_id = 4'd3; b_value = 8'h13;
    q1_id = 4'd15; q2_id = 4'd15;
    repeat (2) @(negedge clock);
    #1;
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rst_a_ready got=%b exp=0", a_ready); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL rst_b_ready got=%b exp=0", b_ready); end
    total++; if (write_id !== 4'd15) begin bad++; $display("FAIL rst_write_id got=%0d exp=15", write_id); end
    total++; if (write_value !== 8'h00) begin bad++; $display("FAIL rst_write_value got=%h exp=00", write_value); end
    total++; if (last_grant !== 1'b0) begin bad++; $display("FAIL rst_last_grant got=%b exp=0", last_grant); end
    a_valid = 1'b0; b_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clock);
    a_valid = 1'b1; a_id = 4'd2; a_value = 8'h55;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL single_a_ready got=%b exp=1", a_ready); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL single_b_ready got=%b exp=0", b_ready); end
    @(negedge clock);
    a_valid = 1'b0;
    total++; if (write_id !== 4'd2) begin bad++; $display("FAIL single_write_id got=%0d exp=2", write_id); end
    total++; if (write_value !== 8'h55) begin bad++; $display("FAIL single_write_value got=%h exp=55", write_value); end
    @(negedge clock);
    total++; if (write_id !== 4'd15) begin bad++; $display("FAIL single_park_id got=%0d exp=15", write_id); end
    total++; if (write_value !== 8'h00) begin bad++; $display("FAIL single_park_value got=%h exp=00", write_value); end
    total++; if (regs[2] !== 8'h55) begin bad++; $display("FAIL single_reg2 got=%h exp=55", regs[2]); end
    total++; if (regs[3] !== 8'h00) begin bad++; $display("FAIL single_reg3 got=%h exp=00", regs[3]); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_id;
    logic [7:0] exp_val;
    // A was served last, so a lone B grant first returns the pointer to A.
    @(negedge clock);
    b_valid = 1'b1; b_id = 4'd4; b_value = 8'h40;
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL cont_pre_b_ready got=%b exp=1", b_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      a_valid = 1'b1; a_id = 4'd1; a_value = 8'h11 + 8'(i);
      b_valid = 1'b1; b_id = 4'd4; b_value = 8'h44 + 8'(i);
      #1;
      total++; if (a_ready !== ((i % 2) == 0)) begin bad++; $display("FAIL cont_a_ready[%0d] got=%b", i, a_ready); end
      total++; if (b_ready !== ((i % 2) == 1)) begin bad++; $display("FAIL cont_b_ready[%0d] got=%b", i, b_ready); end
      exp_id  = ((i % 2) == 0) ? 4'd1 : 4'd4;
      exp_val = ((i % 2) == 0) ? (8'h11 + 8'(i)) : (8'h44 + 8'(i));
      @(posedge clock);
      #1;
      total++; if (write_id !== exp_id) begin bad++; $display("FAIL cont_write_id[%0d] got=%0d exp=%0d", i, write_id, exp_id); end
      total++; if (write_value !== exp_val) begin bad++; $display("FAIL cont_write_value[%0d] got=%h exp=%h", i, write_value, exp_val); end
      total++; if (last_grant !== 1'((i % 2) == 1)) begin bad++; $display("FAIL cont_last_grant[%0d] got=%b", i, last_grant); end
    end
    @(negedge clock);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_same_target();
    @(negedge clock);
    a_valid = 1'b1; a_id = 4'd5; a_value = 8'hAA;
    b_valid = 1'b1; b_id = 4'd5; b_value = 8'hBB;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL same_a_first got=%b exp=1", a_ready); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL same_b_waits got=%b exp=0", b_ready); end
    @(posedge clock);
    #1;
    total++; if (write_value !== 8'hAA) begin bad++; $display("FAIL same_first_value got=%h exp=AA", write_value); end
    @(negedge clock);
    a_valid = 1'b0;
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL same_b_next got=%b exp=1", b_ready); end
    @(posedge clock);
    #1;
    total++; if (write_value !== 8'hBB) begin bad++; $display("FAIL same_second_value got=%h exp=BB", write_value); end
    total++; if (last_grant !== 1'b1) begin bad++; $display("FAIL same_last_grant got=%b exp=1", last_grant); end
    @(negedge clock);
    b_valid = 1'b0;
    @(negedge clock);
    total++; if (regs[5] !== 8'hBB) begin bad++; $display("FAIL same_reg5 got=%h exp=BB", regs[5]); end
  endtask

  task automatic test_hazard();
    @(negedge clock);
    b_valid = 1'b1; b_id = 4'd6; b_value = 8'h66;
    q1_id = 4'd6; q2_id = 4'd7;
    #1;
    total++; if (q1_hazard !== 1'b1) begin bad++; $display("FAIL haz_pending_q1 got=%b exp=1", q1_hazard); end
    total++; if (q2_hazard !== 1'b0) begin bad++; $display("FAIL haz_pending_q2 got=%b exp=0", q2_hazard); end
    @(negedge clock);
    b_valid = 1'b0;
    #1;
    total++; if (write_id !== 4'd6) begin bad++; $display("FAIL haz_write_id got=%0d exp=6", write_id); end
    total++; if (q1_hazard !== 1'b1) begin bad++; $display("FAIL haz_inflight_q1 got=%b exp=1", q1_hazard); end
    // A request raised and withdrawn inside one low phase: flagged, never granted.
    a_valid = 1'b1; a_id = 4'd7; a_value = 8'h70;
    #1;
    total++; if (q2_hazard !== 1'b1) begin bad++; $display("FAIL haz_a_q2 got=%b exp=1", q2_hazard); end
    a_valid = 1'b0;
    @(negedge clock);
    total++; if (q1_hazard !== 1'b0) begin bad++; $display("FAIL haz_drop_q1 got=%b exp=0", q1_hazard); end
    total++; if (write_id !== 4'd15) begin bad++; $display("FAIL haz_withdraw_id got=%0d exp=15", write_id); end
    q1_id = 4'd15;
    #1;
    total++; if (q1_hazard !== 1'b0) begin bad++; $display("FAIL haz_null_q1 got=%b exp=0", q1_hazard); end
    q2_id = 4'd15;
  endtask

  task automatic test_mid_reset();
    @(negedge clock);
    a_valid = 1'b1; a_id = 4'd3; a_value = 8'h77;
    @(posedge clock);
    #1;
    a_valid = 1'b0;
    total++; if (write_id !== 4'd3) begin bad++; $display("FAIL mrst_granted_id got=%0d exp=3", write_id); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (write_id !== 4'd15) begin bad++; $display("FAIL mrst_park_id got=%0d exp=15", write_id); end
    total++; if (write_value !== 8'h00) begin bad++; $display("FAIL mrst_park_value got=%h exp=00", write_value); end
    @(negedge clock);
    reset_n = 1'b1;
    total++; if (regs[3] !== 8'h00) begin bad++; $display("FAIL mrst_reg3 got=%h exp=00", regs[3]); end
    // The A grant had moved the pointer to B; reset must bring it back to A.
    a_valid = 1'b1; a_id = 4'd8; a_value = 8'h88;
    b_valid = 1'b1; b_id = 4'd9; b_value = 8'h99;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL mrst_ptr_a got=%b exp=1", a_ready); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL mrst_ptr_b got=%b exp=0", b_ready); end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_same_target();
    test_hazard();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
